// File: rtl/plab5_mcore_mem_req_sched.sv
// rtl/plab5_mcore_mem_req_sched.sv - shares one memory-net port between icache (port 0) and dcache (port 1)

module plab5_mcore_mem_req_sched #(
  parameter int p_net_src           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_max_outstanding   = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 2,
  localparam int c_req_nbits      = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + 2 + p_mem_data_nbits,
  localparam int c_resp_nbits     = 3 + p_mem_opaque_nbits + 2 + p_mem_data_nbits,
  localparam int c_net_req_nbits  = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + c_req_nbits,
  localparam int c_net_resp_nbits = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + c_resp_nbits
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [c_req_nbits-1:0]      req0_msg,
  input  logic                        req0_val,
  output logic                        req0_rdy,
  input  logic [c_req_nbits-1:0]      req1_msg,
  input  logic                        req1_val,
  output logic                        req1_rdy,

  output logic [c_resp_nbits-1:0]     resp0_msg,
  output logic                        resp0_val,
  input  logic                        resp0_rdy,
  output logic [c_resp_nbits-1:0]     resp1_msg,
  output logic                        resp1_val,
  input  logic                        resp1_rdy,

  output logic [c_net_req_nbits-1:0]  net_req_msg,
  output logic                        net_req_val,
  input  logic                        net_req_rdy,

  input  logic [c_net_resp_nbits-1:0] net_resp_msg,
  input  logic                        net_resp_val,
  output logic                        net_resp_rdy,

  output logic                        err
);

  localparam int c_cnt_nbits     = $clog2(p_max_outstanding + 1);
  localparam int c_dest_nbits    = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
  localparam int c_addr_lsb      = 2 + p_mem_data_nbits;
  localparam int c_req_port_bit  = c_addr_lsb + p_mem_addr_nbits + p_mem_opaque_nbits - 1;
  localparam int c_resp_port_bit = 2 + p_mem_data_nbits + p_mem_opaque_nbits - 1;
  localparam logic [c_cnt_nbits-1:0] c_cnt_max = c_cnt_nbits'(p_max_outstanding);

  logic                       prio;
  logic [c_cnt_nbits-1:0]     cnt0;
  logic [c_cnt_nbits-1:0]     cnt1;
  logic                       qbuf_full;
  logic [c_net_req_nbits-1:0] qbuf_msg;
  logic                       rbuf_full;
  logic                       rbuf_tgt;
  logic [c_resp_nbits-1:0]    rbuf_msg;

  // ---------------- request side ----------------
  logic                           elig0;
  logic                           elig1;
  logic                           grant0;
  logic                           grant1;
  logic                           can_accept;
  logic                           req0_hs;
  logic                           req1_hs;
  logic                           req_hs;
  logic [c_req_nbits-1:0]         win_msg;
  logic [c_req_nbits-1:0]         win_payload;
  logic [c_dest_nbits-1:0]        win_dest;

  assign elig0      = req0_val && (cnt0 < c_cnt_max);
  assign elig1      = req1_val && (cnt1 < c_cnt_max);
  assign grant0     = elig0 && (!elig1 || !prio);
  assign grant1     = elig1 && (!elig0 || prio);
  assign can_accept = !qbuf_full || net_req_rdy;

  assign req0_rdy = can_accept && grant0;
  assign req1_rdy = can_accept && grant1;
  assign req0_hs  = req0_val && req0_rdy;
  assign req1_hs  = req1_val && req1_rdy;
  assign req_hs   = req0_hs || req1_hs;

  assign win_msg  = grant1 ? req1_msg : req0_msg;
  assign win_dest = win_msg[c_addr_lsb + 4 +: c_dest_nbits];

  // Top opaque bit carries the requester id so the response can be steered back.
  always_comb begin
    win_payload                 = win_msg;
    win_payload[c_req_port_bit] = grant1;
  end

  assign net_req_val = qbuf_full;
  assign net_req_msg = qbuf_msg;

  // ---------------- response side ----------------
  logic [c_resp_nbits-1:0] in_payload;
  logic [c_resp_nbits-1:0] in_clean;
  logic                    in_tgt;
  logic                    in_cnt_zero;
  logic                    tgt_rdy;
  logic                    net_resp_hs;
  logic                    resp0_hs;
  logic                    resp1_hs;
  logic                    unused_net_hdr;

  assign in_payload     = net_resp_msg[c_resp_nbits-1:0];
  assign in_tgt         = in_payload[c_resp_port_bit];
  assign unused_net_hdr = ^net_resp_msg[c_net_resp_nbits-1:c_resp_nbits];

  always_comb begin
    in_clean                  = in_payload;
    in_clean[c_resp_port_bit] = 1'b0;
  end

  // A same-cycle request handshake makes the zero count legitimately non-zero.
  assign in_cnt_zero = in_tgt ? ((cnt1 == '0) && !req1_hs)
                              : ((cnt0 == '0) && !req0_hs);

  assign tgt_rdy      = rbuf_tgt ? resp1_rdy : resp0_rdy;
  assign net_resp_rdy = !rbuf_full || tgt_rdy;
  assign net_resp_hs  = net_resp_val && net_resp_rdy;

  assign resp0_val = rbuf_full && !rbuf_tgt;
  assign resp1_val = rbuf_full && rbuf_tgt;
  assign resp0_msg = rbuf_msg;
  assign resp1_msg = rbuf_msg;
  assign resp0_hs  = resp0_val && resp0_rdy;
  assign resp1_hs  = resp1_val && resp1_rdy;

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio      <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
      qbuf_full <= 1'b0;
      qbuf_msg  <= '0;
      rbuf_full <= 1'b0;
      rbuf_tgt  <= 1'b0;
      rbuf_msg  <= '0;
      err       <= 1'b0;
    end else begin
      if (req_hs) begin
        qbuf_full <= 1'b1;
        qbuf_msg  <= {p_net_srcdest_nbits'(win_dest),
                      p_net_srcdest_nbits'(p_net_src),
                      {p_net_opaque_nbits{1'b0}},
                      win_payload};
        prio      <= req0_hs;
      end else if (net_req_rdy) begin
        qbuf_full <= 1'b0;
      end

      case ({req0_hs, resp0_hs})
        2'b10:   cnt0 <= cnt0 + 1'b1;
        2'b01:   cnt0 <= cnt0 - 1'b1;
        default: cnt0 <= cnt0;
      endcase

      case ({req1_hs, resp1_hs})
        2'b10:   cnt1 <= cnt1 + 1'b1;
        2'b01:   cnt1 <= cnt1 - 1'b1;
        default: cnt1 <= cnt1;
      endcase

      if (resp0_hs || resp1_hs) begin
        rbuf_full <= 1'b0;
      end
      if (net_resp_hs && !in_cnt_zero) begin
        rbuf_full <= 1'b1;
        rbuf_tgt  <= in_tgt;
        rbuf_msg  <= in_clean;
      end
      if (net_resp_hs && in_cnt_zero) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_sched.sv
// tb/tb_plab5_mcore_mem_req_sched.sv - directed table and sequence bench for the memory request scheduler

module tb_plab5_mcore_mem_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [76:0] req0_msg;
  logic        req0_val;
  logic        req0_rdy;
  logic [76:0] req1_msg;
  logic        req1_val;
  logic        req1_rdy;
  logic [44:0] resp0_msg;
  logic        resp0_val;
  logic        resp0_rdy;
  logic [44:0] resp1_msg;
  logic        resp1_val;
  logic        resp1_rdy;
  logic [84:0] net_req_msg;
  logic        net_req_val;
  logic        net_req_rdy;
  logic [52:0] net_resp_msg;
  logic        net_resp_val;
  logic        net_resp_rdy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  plab5_mcore_mem_req_sched #(.p_net_src(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_msg     (req0_msg),
    .req0_val     (req0_val),
    .req0_rdy     (req0_rdy),
    .req1_msg     (req1_msg),
    .req1_val     (req1_val),
    .req1_rdy     (req1_rdy),
    .resp0_msg    (resp0_msg),
    .resp0_val    (resp0_val),
    .resp0_rdy    (resp0_rdy),
    .resp1_msg    (resp1_msg),
    .resp1_val    (resp1_val),
    .resp1_rdy    (resp1_rdy),
    .net_req_msg  (net_req_msg),
    .net_req_val  (net_req_val),
    .net_req_rdy  (net_req_rdy),
    .net_resp_msg (net_resp_msg),
    .net_resp_val (net_resp_val),
    .net_resp_rdy (net_resp_rdy),
    .err          (err)
  );

  typedef struct {
    logic       r0v;
    logic       r1v;
    logic       nrdy;
    logic       e_r0rdy;
    logic       e_r1rdy;
    logic       e_nval;
    logic [1:0] e_dest;
    logic [7:0] e_opq;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] opq,
                                         input logic [31:0] addr, input logic [1:0] len,
                                         input logic [31:0] data);
    return {t, opq, addr, len, data};
  endfunction

  // Net header fields are deliberately non-zero; the block must ignore them.
  function automatic logic [52:0] mk_nresp(input logic [7:0] opq, input logic [31:0] data);
    return {2'd3, 2'd1, 4'hf, 3'd0, opq, 2'd0, data};
  endfunction

  function automatic logic [44:0] mk_resp(input logic [7:0] opq, input logic [31:0] data);
    return {3'd0, opq, 2'd0, data};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    req0_val     = 1'b0;
    req1_val     = 1'b0;
    net_req_rdy  = 1'b1;
    net_resp_val = 1'b0;
    net_resp_msg = '0;
    resp0_rdy    = 1'b1;
    resp1_rdy    = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    req0_msg = mk_req(3'd0, 8'h01, 32'h00001024, 2'd1, 32'h0);
    req1_msg = mk_req(3'd0, 8'h13, 32'h000010fc, 2'd0, 32'h0);

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'h01};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'h93};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h01};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'h01};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h93};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'h93};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'h01};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 8'h93};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h01};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};

    // Reset state
    do_reset();
    settle();
    chk("rst_net_req_val", net_req_val, 1'b0);
    chk("rst_resp0_val", resp0_val, 1'b0);
    chk("rst_resp1_val", resp1_val, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_net_resp_rdy", net_resp_rdy, 1'b1);

    // Single request held by net backpressure
    req0_val = 1'b1;
    net_req_rdy = 1'b0;
    settle();
    chk("t1_accept_rdy", req0_rdy, 1'b1);
    chk("t1_accept_nval", net_req_val, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_hold_nval", net_req_val, 1'b1);
      chk("t1_hold_msg", net_req_msg,
          {2'd2, 2'd1, 4'd0, mk_req(3'd0, 8'h01, 32'h00001024, 2'd1, 32'h0)});
      chk("t1_hold_rdy", req0_rdy, 1'b0);
      tick();
    end
    req0_val = 1'b0;
    net_req_rdy = 1'b1;
    settle();
    chk("t1_drain_nval", net_req_val, 1'b1);
    tick();
    settle();
    chk("t1_empty_nval", net_req_val, 1'b0);

    // Round-robin and outstanding limit table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req0_val    = tbl[i].r0v;
      req1_val    = tbl[i].r1v;
      net_req_rdy = tbl[i].nrdy;
      settle();
      chk($sformatf("rr%0d_req0_rdy", i), req0_rdy, tbl[i].e_r0rdy);
      chk($sformatf("rr%0d_req1_rdy", i), req1_rdy, tbl[i].e_r1rdy);
      chk($sformatf("rr%0d_nval", i), net_req_val, tbl[i].e_nval);
      if (tbl[i].e_nval) begin
        chk($sformatf("rr%0d_dest", i), net_req_msg[84:83], tbl[i].e_dest);
        chk($sformatf("rr%0d_opq", i), net_req_msg[73:66], tbl[i].e_opq);
      end
      tick();
    end
    idle();

    // cnt1 at limit; one response frees a slot
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h90, 32'h11111111);
    req1_val = 1'b1;
    settle();
    chk("lim_net_resp_rdy", net_resp_rdy, 1'b1);
    chk("lim_req1_blocked", req1_rdy, 1'b0);
    chk("lim_resp1_early", resp1_val, 1'b0);
    tick();
    net_resp_val = 1'b0;
    settle();
    chk("lim_resp1_val", resp1_val, 1'b1);
    chk("lim_resp0_val", resp0_val, 1'b0);
    chk("lim_resp1_msg", resp1_msg, mk_resp(8'h10, 32'h11111111));
    chk("lim_req1_still_blocked", req1_rdy, 1'b0);
    tick();
    settle();
    chk("lim_resp1_gone", resp1_val, 1'b0);
    chk("lim_req1_regrant", req1_rdy, 1'b1);
    tick();
    req1_val = 1'b0;
    settle();
    chk("lim_nreq_opq", net_req_msg[73:66], 8'h93);
    tick();

    // Response backpressure on port 0
    resp0_rdy = 1'b0;
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h05, 32'habcdef01);
    settle();
    chk("bp_first_rdy", net_resp_rdy, 1'b1);
    tick();
    net_resp_msg = mk_nresp(8'h06, 32'h22222222);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("bp_stall_rdy", net_resp_rdy, 1'b0);
      chk("bp_stall_val", resp0_val, 1'b1);
      chk("bp_stall_msg", resp0_msg, mk_resp(8'h05, 32'habcdef01));
      tick();
    end
    resp0_rdy = 1'b1;
    settle();
    chk("bp_release_rdy", net_resp_rdy, 1'b1);
    chk("bp_release_msg", resp0_msg, mk_resp(8'h05, 32'habcdef01));
    tick();
    net_resp_val = 1'b0;
    settle();
    chk("bp_second_val", resp0_val, 1'b1);
    chk("bp_second_msg", resp0_msg, mk_resp(8'h06, 32'h22222222));
    tick();
    settle();
    chk("bp_done_val", resp0_val, 1'b0);

    // Simultaneous increment and decrement on port 0 (cnt0 = 2 here)
    resp0_rdy = 1'b0;
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h07, 32'h33333333);
    tick();
    net_resp_val = 1'b0;
    resp0_rdy = 1'b1;
    req0_val = 1'b1;
    settle();
    chk("sim_req0_rdy", req0_rdy, 1'b1);
    chk("sim_resp0_val", resp0_val, 1'b1);
    tick();
    resp0_rdy = 1'b0;
    settle();
    chk("sim_after_rdy_a", req0_rdy, 1'b1);
    tick();
    settle();
    chk("sim_after_rdy_b", req0_rdy, 1'b1);
    tick();
    settle();
    chk("sim_after_limit", req0_rdy, 1'b0);
    tick();
    idle();
    tick();

    // Unmatched response, then asynchronous reset mid-stream
    do_reset();
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h85, 32'h55555555);
    settle();
    chk("err_accept_rdy", net_resp_rdy, 1'b1);
    tick();
    net_resp_val = 1'b0;
    settle();
    chk("err_set", err, 1'b1);
    chk("err_no_resp1", resp1_val, 1'b0);
    req0_val = 1'b1;
    net_req_rdy = 1'b0;
    settle();
    chk("err_sticky", err, 1'b1);
    chk("err_req0_rdy", req0_rdy, 1'b1);
    tick();
    req0_val = 1'b0;
    resp0_rdy = 1'b0;
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h01, 32'h44444444);
    settle();
    chk("ar_net_resp_rdy", net_resp_rdy, 1'b1);
    chk("ar_nval_pre", net_req_val, 1'b1);
    tick();
    net_resp_val = 1'b0;
    settle();
    chk("ar_resp0_pre", resp0_val, 1'b1);
    reset = 1'b0;
    #1;
    chk("ar_nval_drop", net_req_val, 1'b0);
    chk("ar_resp0_drop", resp0_val, 1'b0);
    chk("ar_resp1_drop", resp1_val, 1'b0);
    chk("ar_err_drop", err, 1'b0);
    tick();
    idle();
    reset = 1'b1;
    net_resp_val = 1'b1;
    net_resp_msg = mk_nresp(8'h02, 32'h66666666);
    tick();
    net_resp_val = 1'b0;
    settle();
    chk("ar_cnt0_cleared_err", err, 1'b1);
    chk("ar_cnt0_cleared_resp", resp0_val, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_sched.md
Name: plab5_mcore_mem_req_sched

Overview:
Shares one memory-network request/response port between two cache-side requesters: port 0 is the icache, port 1 is the dcache.
- Request path: round-robin arbitration, conversion of the winning memory request into a network message, and per-requester outstanding-request tracking.
- Response path: steers network responses back to the originating requester.
- Sits between a core's L1 caches and the memory-side ring of the multicore.

Parameters:
p_net_src, 0, source id stamped in every outgoing net message
p_num_ports, 4, number of memory banks/net ports; dest = addr[5:4] for 4 ports
p_max_outstanding, 4, maximum in-flight requests per requester (counter width clog2(p+1))
p_mem_opaque_nbits, 8, memory message opaque width
p_mem_addr_nbits, 32, memory address width
p_mem_data_nbits, 32, memory data width
p_net_opaque_nbits, 4, net message opaque width
p_net_srcdest_nbits, 2, net src/dest width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req0_msg / req1_msg  in  77  memory request (type 3, opaque 8, addr 32, len 2, data 32)
req0_val / req1_val  in  1  request valid
req0_rdy / req1_rdy  out  1  request ready
resp0_msg / resp1_msg  out  45  memory response (type 3, opaque 8, len 2, data 32)
resp0_val / resp1_val  out  1  response valid
resp0_rdy / resp1_rdy  in  1  response ready
net_req_msg  out  85  net message {dest 2, src 2, opaque 4, payload 77}, standard net layout
net_req_val  out  1  net request valid
net_req_rdy  in  1  net request ready
net_resp_msg  in  53  net message carrying a 45-bit memory response payload
net_resp_val  in  1  net response valid
net_resp_rdy  out  1  net response ready
err  out  1  sticky: unmatched response received

Behaviour:
Reset:
- Asynchronous assert while reset=0.
- All val outputs 0, err 0, both outstanding counters 0, round-robin priority to port 0.
- Request and response buffers empty. Msg outputs are don't-care.
- Reset mid-transfer discards buffered messages and counters.

Request buffer and arbitration:
- One-entry registered request buffer; net_req_val = buffer full.
- Buffer accepts a new request when empty, or when full with net_req_rdy=1 (drain and refill in the same cycle).
- Port i is eligible when reqi_val=1 and cnt_i < p_max_outstanding.
- reqi_rdy = buffer-can-accept AND port i granted. At most one rdy is high per cycle. rdy may depend on val.
- Round-robin: when both ports are eligible, the priority holder wins. After any grant, priority moves to the other port. With a single eligible port, that port wins and priority still flips.

Request conversion (registered, latency 1 cycle from accept to net_req_val):
- dest = addr[5:4]; src = p_net_src; net opaque = 0.
- payload = request with opaque[7] overwritten by the port id (0 = icache, 1 = dcache). Opaque bits [6:0] pass through unchanged. Requesters keep opaque[7]=0.

Outstanding counters:
- cnt_i increments on the reqi handshake and decrements on the respi handshake.
- Both in the same cycle leaves cnt_i unchanged.
- Saturation is prevented by the eligibility rule.

Response path:
- One-entry response buffer. net_resp_rdy = buffer empty, or buffer full and the target respi_rdy=1.
- Target port = payload opaque[7]. respi_val = buffer full and target==i. Delivered message has opaque[7] cleared.
- Latency: 1 cycle from net handshake to respi_val.
- Net src/dest/opaque of incoming responses are ignored.
- A response whose target counter is 0 and which is not being incremented: err set (sticky until reset), response dropped, no counter underflow.
- Request and response paths operate concurrently and independently.

Test Plan:
1. Single request: reset release; req0 read opq 8'h01 addr 32'h00001024 len 1 -> one cycle later net_req_val=1, dest 2'h2, src p_net_src, payload opaque 8'h01; hold net_req_rdy=0 for 3 cycles -> msg stable, req rdy low for the buffer's lifetime until drain.
2. Round-robin: req0 and req1 both valid continuously, net_req_rdy=1 -> grants alternate 0,1,0,1. Second grant carries opaque[7]=1, e.g. opq 8'h13 -> 8'h93, dest from addr 32'h000010fc = 2'h3.
3. Outstanding limit: 4 req1 accepted with no responses -> req1_rdy=0 while req0 still granted. Return one response opaque 8'h90 -> resp1_val with opaque 8'h10, cnt1=3, req1 accepted again next cycle.
4. Response backpressure: response for port 0 while resp0_rdy=0 -> net_resp_rdy=0 until resp0_rdy=1. Response delivered exactly once with data 32'habcdef01 intact.
5. Simultaneous inc/dec: req0 handshake and resp0 handshake in the same cycle -> cnt0 unchanged.
6. Error and reset: response opaque 8'h85 with cnt1=0 -> err=1, no resp1_val. Assert reset mid-stream -> all vals and err drop immediately (asynchronously), counters return to 0.
